display_scan_scheduler: RTL

//   Time-multiplexing scheduler for a common-segment multi-digit 7-seg display.

---
 rtl/display_scan_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_scheduler.sv
// ============================================================================
// Module      : display_scan_scheduler
// Description : Multiplexes digits of a common-segment 7-seg display, with
//               dead-time blanking between digits and loads applied per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_scheduler #(
    parameter int N_DIGITS     = 2,
    parameter int DWELL_CYCLES = 60000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*N_DIGITS-1:0]   load_data,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     select,
    output logic [2:0]              digit_idx,
    output logic                    frame_start
);

    localparam int C_MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);
    localparam int C_DATA_W     = 4 * N_DIGITS;

    localparam logic [C_CNT_W-1:0] C_BLANK_LOAD = C_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_DWELL_LOAD = C_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]         C_LAST_IDX   = 3'(N_DIGITS - 1);
    localparam logic [6:0]         C_SEG_OFF    = 7'h7F;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;

    logic [1:0]          state_q,       state_d;
    logic [C_CNT_W-1:0]  cnt_q,         cnt_d;
    logic [2:0]          idx_q,         idx_d;
    logic [C_DATA_W-1:0] shadow_q,      shadow_d;
    logic [C_DATA_W-1:0] pending_q,     pending_d;
    logic                pending_full_q, pending_full_d;
    logic                load_ready_q,  load_ready_d;
    logic [6:0]          seg_q,         seg_d;
    logic [N_DIGITS-1:0] select_q,      select_d;
    logic                frame_start_q, frame_start_d;

    logic                w_wrap;
    logic                w_take;
    logic                w_commit;
    logic [3:0]          w_nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= 3'd0;
            shadow_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            load_ready_q   <= 1'b1;
            seg_q          <= C_SEG_OFF;
            select_q       <= '1;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            load_ready_q   <= load_ready_d;
            seg_q          <= seg_d;
            select_q       <= select_d;
            frame_start_q  <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: slot sequencing and load handshake
    // ------------------------------------------------------------------
    assign w_wrap = (state_q == S_ON) && (cnt_q == '0) && enable && (idx_q == C_LAST_IDX);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_start_d = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_BLANK;
                    cnt_d         = C_BLANK_LOAD;
                    idx_d         = 3'd0;
                    frame_start_d = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = S_ON;
                        cnt_d   = C_DWELL_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        state_d = S_BLANK;
                        cnt_d   = C_BLANK_LOAD;
                        if (idx_q == C_LAST_IDX) begin
                            idx_d         = 3'd0;
                            frame_start_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // Capture and commit are mutually exclusive: ready is low while pending is full.
    assign w_take   = load_valid && load_ready_q;
    assign w_commit = pending_full_q && ((state_q == S_IDLE) || w_wrap);

    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        shadow_d       = shadow_q;
        if (w_take) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end else if (w_commit) begin
            shadow_d       = pending_q;
            pending_full_d = 1'b0;
        end
        load_ready_d = ~pending_full_d;
    end

    // ------------------------------------------------------------------
    // Output logic: registered pins follow the next state
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                w_nibble = shadow_d[4*i +: 4];
            end
        end
    end

    always_comb begin
        seg_d    = C_SEG_OFF;
        select_d = '1;
        if (state_d == S_ON) begin
            seg_d = hex_to_seg(w_nibble);
            for (int i = 0; i < N_DIGITS; i++) begin
                select_d[i] = (idx_d != 3'(i));
            end
        end
    end

    assign seg         = seg_q;
    assign select      = select_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;
    assign load_ready  = load_ready_q;

endmodule

`default_nettype wire
